// File: rtl/mult_ctrl_taint_param_if.sv
// Handshake bundle between the multiplier controller and its datapath/taint harness.
interface mult_ctrl_taint_param_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             start_t;
   logic [WIDTH-1:0] multiplierReg;
   logic [WIDTH-1:0] multiplierReg_t;
   logic             mdld,   mrld,   rsclear,   rsload,   rssub,   rsshr,   productDone,   busy;
   logic             mdld_t, mrld_t, rsclear_t, rsload_t, rssub_t, rsshr_t, productDone_t, busy_t;

   modport master (
      output start, start_t, multiplierReg, multiplierReg_t,
      input  mdld, mrld, rsclear, rsload, rssub, rsshr, productDone, busy,
      input  mdld_t, mrld_t, rsclear_t, rsload_t, rssub_t, rsshr_t, productDone_t, busy_t
   );

   modport slave (
      input  start, start_t, multiplierReg, multiplierReg_t,
      output mdld, mrld, rsclear, rsload, rssub, rsshr, productDone, busy,
      output mdld_t, mrld_t, rsclear_t, rsload_t, rssub_t, rsshr_t, productDone_t, busy_t
   );
endinterface

// File: rtl/mult_ctrl_taint_param.sv
// Shift-add multiplier control FSM with sticky per-state taint tracking.
// Optional macro MULT_CTRL_TAINT_CLR_EN adds a taint_clr input honoured in IDLE.
module mult_ctrl_taint_param #(
   parameter int WIDTH  = 4,
   parameter bit SIGNED = 1'b0
) (
   input  logic clk,
   input  logic rst,
`ifdef MULT_CTRL_TAINT_CLR_EN
   input  logic taint_clr,
`endif
   mult_ctrl_taint_param_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   localparam int I_IDLE  = 0;
   localparam int I_INIT  = 1;
   localparam int I_TEST  = 2;
   localparam int I_ADD   = 3;
   localparam int I_SUB   = 4;
   localparam int I_SHIFT = 5;
   localparam int I_DONE  = 6;

   typedef enum logic [6:0] {
      S_IDLE  = 7'b0000001,
      S_INIT  = 7'b0000010,
      S_TEST  = 7'b0000100,
      S_ADD   = 7'b0001000,
      S_SUB   = 7'b0010000,
      S_SHIFT = 7'b0100000,
      S_DONE  = 7'b1000000
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       st_t_q, st_t_d;
   logic             cnt_t_q, cnt_t_d;
   logic             mr_bit, mr_bit_t;

   // Taint mask of every state reachable in one step from s
   function automatic logic [6:0] succ(input state_e s);
      logic [6:0] m;
      m = '0;
      unique case (s)
         S_IDLE:  begin m[I_IDLE] = 1'b1; m[I_INIT] = 1'b1; end
         S_INIT:  m[I_TEST] = 1'b1;
         S_TEST:  begin m[I_ADD] = 1'b1; m[I_SHIFT] = 1'b1; m[I_SUB] = SIGNED; end
         S_ADD:   m[I_SHIFT] = 1'b1;
         S_SUB:   m[I_SHIFT] = 1'b1;
         S_SHIFT: begin m[I_TEST] = 1'b1; m[I_DONE] = 1'b1; end
         S_DONE:  m[I_IDLE] = 1'b1;
         default: m = '0;
      endcase
      return m;
   endfunction

   always_comb begin
      mr_bit   = 1'b0;
      mr_bit_t = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            mr_bit   = bus.multiplierReg[i];
            mr_bit_t = bus.multiplierReg_t[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         st_t_q  <= '0;
         cnt_t_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         st_t_q  <= st_t_d;
         cnt_t_q <= cnt_t_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_IDLE:  if (bus.start) state_d = S_INIT;
         S_INIT:  begin state_d = S_TEST; cnt_d = '0; end
         S_TEST: begin
            if (!mr_bit)                     state_d = S_SHIFT;
            else if (SIGNED && cnt_q == LAST) state_d = S_SUB;
            else                             state_d = S_ADD;
         end
         S_ADD:   state_d = S_SHIFT;
         S_SUB:   state_d = S_SHIFT;
         S_SHIFT: begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_q == LAST) ? S_DONE : S_TEST;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      st_t_d  = st_t_q;
      cnt_t_d = cnt_t_q | st_t_q[I_SHIFT] | st_t_q[I_INIT];
      if (|(st_t_q & state_q)) st_t_d = st_t_d | succ(state_q);
      if (state_q == S_IDLE && bus.start_t) begin
         st_t_d[I_IDLE] = 1'b1;
         st_t_d[I_INIT] = 1'b1;
      end
      if (state_q == S_TEST && (mr_bit_t || cnt_t_q)) begin
         st_t_d[I_ADD]   = 1'b1;
         st_t_d[I_SHIFT] = 1'b1;
         if (SIGNED) st_t_d[I_SUB] = 1'b1;
      end
      if (state_q == S_SHIFT && cnt_t_q) begin
         st_t_d[I_TEST] = 1'b1;
         st_t_d[I_DONE] = 1'b1;
      end
`ifdef MULT_CTRL_TAINT_CLR_EN
      // Clear outranks a simultaneous start_t
      if (state_q == S_IDLE && taint_clr) begin
         st_t_d  = '0;
         cnt_t_d = 1'b0;
      end
`endif
   end

   always_comb begin
      bus.mdld          = (state_q == S_INIT);
      bus.mrld          = (state_q == S_INIT);
      bus.rsclear       = (state_q == S_INIT);
      bus.rsload        = (state_q == S_ADD);
      bus.rssub         = SIGNED && (state_q == S_SUB);
      bus.rsshr         = (state_q == S_SHIFT);
      bus.productDone   = (state_q == S_DONE);
      bus.busy          = (state_q != S_IDLE);
      bus.mdld_t        = st_t_q[I_INIT];
      bus.mrld_t        = st_t_q[I_INIT];
      bus.rsclear_t     = st_t_q[I_INIT];
      bus.rsload_t      = st_t_q[I_ADD];
      bus.rssub_t       = st_t_q[I_SUB];
      bus.rsshr_t       = st_t_q[I_SHIFT];
      bus.productDone_t = st_t_q[I_DONE];
      bus.busy_t        = |st_t_q[6:1];
   end
endmodule

// File: tb/tb_mult_ctrl_taint_param.sv
// Bench for mult_ctrl_taint_param: unsigned and signed instances driven in lockstep
// and compared each cycle against a schedule-queue reference model.
module tb_mult_ctrl_taint_param;
   localparam int W = 4;
   localparam int P_IDLE = 0, P_INIT = 1, P_TEST = 2, P_ADD = 3, P_SUB = 4, P_SHIFT = 5, P_DONE = 6;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0, start_t = 1'b0, taint_clr = 1'b0;
   logic [W-1:0] mr = '0, mr_t = '0;

   always #5 clk = ~clk;

   mult_ctrl_taint_param_if #(.WIDTH(W)) b0 ();
   mult_ctrl_taint_param_if #(.WIDTH(W)) b1 ();

   assign b0.start = start;  assign b0.start_t = start_t;
   assign b0.multiplierReg = mr;  assign b0.multiplierReg_t = mr_t;
   assign b1.start = start;  assign b1.start_t = start_t;
   assign b1.multiplierReg = mr;  assign b1.multiplierReg_t = mr_t;

   mult_ctrl_taint_param #(.WIDTH(W), .SIGNED(1'b0)) u0 (
      .clk(clk), .rst(rst),
`ifdef MULT_CTRL_TAINT_CLR_EN
      .taint_clr(taint_clr),
`endif
      .bus(b0)
   );
   mult_ctrl_taint_param #(.WIDTH(W), .SIGNED(1'b1)) u1 (
      .clk(clk), .rst(rst),
`ifdef MULT_CTRL_TAINT_CLR_EN
      .taint_clr(taint_clr),
`endif
      .bus(b1)
   );

   // bit order: mdld mrld rsclear rsload rssub rsshr productDone busy, then the same taints
   logic [15:0] obs0, obs1;
   assign obs0 = {b0.busy_t, b0.productDone_t, b0.rsshr_t, b0.rssub_t, b0.rsload_t, b0.rsclear_t, b0.mrld_t, b0.mdld_t,
                  b0.busy, b0.productDone, b0.rsshr, b0.rssub, b0.rsload, b0.rsclear, b0.mrld, b0.mdld};
   assign obs1 = {b1.busy_t, b1.productDone_t, b1.rsshr_t, b1.rssub_t, b1.rsload_t, b1.rsclear_t, b1.mrld_t, b1.mdld_t,
                  b1.busy, b1.productDone, b1.rsshr, b1.rssub, b1.rsload, b1.rsclear, b1.mrld, b1.mdld};

   int ncmp = 0, nerr = 0, tcyc = 0;

   // reference model: current phase, pending schedule of (phase, bit) slots, tainted-phase set
   int         cur[2], curb[2], head[2], len[2];
   int         sph[2][16], sbt[2][16];
   logic [6:0] tt[2];
   logic       ct[2];

   // per-operation observations
   int   opc[2], nload[2], nsub[2], nshr[2], done_c[2], sub_c[2], shrt_c[2];
   logic tor[2], initt[2], dnt[2];

   function automatic logic [6:0] bitm(input int p);
      logic [6:0] m;
      m = '0;
      m[p] = 1'b1;
      return m;
   endfunction

   function automatic logic [6:0] succ(input int p, input bit sg);
      case (p)
         P_IDLE:  return bitm(P_IDLE) | bitm(P_INIT);
         P_INIT:  return bitm(P_TEST);
         P_TEST:  return bitm(P_ADD) | bitm(P_SHIFT) | (sg ? bitm(P_SUB) : 7'd0);
         P_ADD:   return bitm(P_SHIFT);
         P_SUB:   return bitm(P_SHIFT);
         P_SHIFT: return bitm(P_TEST) | bitm(P_DONE);
         default: return bitm(P_IDLE);
      endcase
   endfunction

   function automatic logic [15:0] expv(input int s);
      logic [15:0] e;
      int p;
      p = cur[s];
      e = '0;
      e[0] = (p == P_INIT); e[1] = (p == P_INIT); e[2] = (p == P_INIT);
      e[3] = (p == P_ADD);  e[4] = (p == P_SUB);  e[5] = (p == P_SHIFT);
      e[6] = (p == P_DONE); e[7] = (p != P_IDLE);
      e[8] = tt[s][P_INIT]; e[9] = tt[s][P_INIT]; e[10] = tt[s][P_INIT];
      e[11] = tt[s][P_ADD]; e[12] = tt[s][P_SUB]; e[13] = tt[s][P_SHIFT];
      e[14] = tt[s][P_DONE]; e[15] = |tt[s][6:1];
      return e;
   endfunction

   task automatic mstep(input int s, input bit sg);
      int p, b;
      logic [6:0] nt;
      logic nct;
      p = cur[s];
      b = curb[s];
      if (rst) begin
         cur[s] = P_IDLE; curb[s] = 0; head[s] = 0; len[s] = 0; tt[s] = '0; ct[s] = 1'b0;
         return;
      end
      nt  = tt[s];
      nct = ct[s] | tt[s][P_SHIFT] | tt[s][P_INIT];
      if (tt[s][p]) nt = nt | succ(p, sg);
      if (p == P_IDLE && start_t) nt = nt | bitm(P_IDLE) | bitm(P_INIT);
      if (p == P_TEST && (mr_t[b] || ct[s])) nt = nt | bitm(P_ADD) | bitm(P_SHIFT) | (sg ? bitm(P_SUB) : 7'd0);
      if (p == P_SHIFT && ct[s]) nt = nt | bitm(P_TEST) | bitm(P_DONE);
`ifdef MULT_CTRL_TAINT_CLR_EN
      if (p == P_IDLE && taint_clr) begin nt = '0; nct = 1'b0; end
`endif
      tt[s] = nt;
      ct[s] = nct;
      if (p == P_IDLE) begin
         if (start) begin
            len[s] = 0; head[s] = 0;
            for (int i = 0; i < W; i++) begin
               sph[s][len[s]] = P_TEST;  sbt[s][len[s]] = i; len[s]++;
               sph[s][len[s]] = P_SHIFT; sbt[s][len[s]] = i; len[s]++;
            end
            sph[s][len[s]] = P_DONE; sbt[s][len[s]] = 0; len[s]++;
            cur[s] = P_INIT;
         end
      end else if (p == P_TEST && mr[b]) begin
         cur[s] = (sg && b == W - 1) ? P_SUB : P_ADD;
      end else if (head[s] < len[s]) begin
         cur[s] = sph[s][head[s]]; curb[s] = sbt[s][head[s]]; head[s]++;
      end else begin
         cur[s] = P_IDLE;
      end
   endtask

   task automatic chk(input string tag, input int o, input int e);
      ncmp++;
      assert (o === e) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, o, e);
      end
   endtask

   task automatic clr_stats();
      for (int s = 0; s < 2; s++) begin
         opc[s] = 0; nload[s] = 0; nsub[s] = 0; nshr[s] = 0; done_c[s] = 0; sub_c[s] = 0; shrt_c[s] = 0;
         tor[s] = 1'b0; initt[s] = 1'b0; dnt[s] = 1'b0;
      end
   endtask

   task automatic cyc();
      logic [15:0] o, e;
      for (int s = 0; s < 2; s++) begin
         o = (s == 0) ? obs0 : obs1;
         e = expv(s);
         ncmp++;
         assert (o === e) else begin
            nerr++;
            $error("FAIL model_u%0d cycle %0d: observed %h expected %h", s, tcyc, o, e);
         end
         if (o[0]) begin opc[s] = 1; initt[s] = o[8]; end
         else if (opc[s] != 0) opc[s]++;
         if (o[3]) nload[s]++;
         if (o[4]) begin nsub[s]++; sub_c[s] = opc[s]; end
         if (o[5]) nshr[s]++;
         if (o[6]) begin done_c[s] = opc[s]; dnt[s] = o[14]; end
         if (o[13] && shrt_c[s] == 0) shrt_c[s] = opc[s];
         tor[s] = tor[s] | (|o[15:8]);
      end
      mstep(0, 1'b0);
      mstep(1, 1'b1);
      @(posedge clk);
      #1;
      tcyc++;
   endtask

   task automatic launch(input logic [W-1:0] m, input logic [W-1:0] mt, input logic st, input logic c);
      clr_stats();
      mr = m; mr_t = mt; start = 1'b1; start_t = st; taint_clr = c;
      cyc();
      start = 1'b0; start_t = 1'b0; taint_clr = 1'b0;
   endtask

   task automatic op(input logic [W-1:0] m, input logic [W-1:0] mt, input logic st, input logic c);
      launch(m, mt, st, c);
      for (int i = 0; i < 40; i++) begin
         if (done_c[0] != 0) break;
         cyc();
      end
      chk("op_completes", int'(done_c[0] != 0), 1);
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         cur[s] = P_IDLE; curb[s] = 0; head[s] = 0; len[s] = 0; tt[s] = '0; ct[s] = 1'b0;
      end
      clr_stats();
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_u0", int'(obs0), 0);
      chk("reset_u1", int'(obs1), 0);
      cyc();
      rst = 1'b0;
      cyc();

      // unsigned 1011: three adds, four shifts, done in cycle 13
      op(4'b1011, 4'b0000, 1'b0, 1'b0);
      chk("u0_1011_load", nload[0], 3);
      chk("u0_1011_shr", nshr[0], 4);
      chk("u0_1011_done", done_c[0], 13);
      chk("u0_1011_taint", int'(tor[0]), 0);
      chk("u1_1011_load", nload[1], 2);
      chk("u1_1011_sub", nsub[1], 1);
      chk("u1_1011_done", done_c[1], 13);

      // back-to-back: signed 1000 subtracts once in cycle 9
      op(4'b1000, 4'b0000, 1'b0, 1'b0);
      chk("u1_1000_sub", nsub[1], 1);
      chk("u1_1000_subcyc", sub_c[1], 9);
      chk("u1_1000_load", nload[1], 0);
      chk("u1_1000_done", done_c[1], 11);
      chk("u0_1000_load", nload[0], 1);
      chk("u0_1000_sub", nsub[0], 0);

      // multiplier bit 2 tainted: add/shift taint appears after bit-2 TEST
      op(4'b0000, 4'b0100, 1'b0, 1'b0);
      chk("mrt_shr_t_first", shrt_c[0], 7);
      chk("mrt_rsload_t", int'(obs0[11]), 1);
      chk("mrt_rsshr_t", int'(obs0[13]), 1);
      chk("mrt_mdld_t", int'(obs0[8]), 0);
      chk("mrt_u0_rssub_t", int'(obs0[12]), 0);
      chk("mrt_u1_rssub_t", int'(obs1[12]), 1);
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("rst_clears_taint", int'(obs0), 0);

      // tainted start propagates to DONE and into the next operation
      op(4'b0101, 4'b0000, 1'b1, 1'b0);
      chk("st_init_t", int'(initt[0]), 1);
      chk("st_done_t", int'(dnt[0]), 1);
      chk("st_done_t_idle", int'(obs0[14]), 1);
      op(4'b0010, 4'b0000, 1'b0, 1'b0);
      chk("st_next_init_t", int'(initt[0]), 1);
      chk("st_next_done", done_c[0], 11);
      rst = 1'b1; cyc(); rst = 1'b0;

      // reset in the ADD cycle of bit 1
      launch(4'b0011, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (opc[0] == 5) break;
         cyc();
      end
      chk("add_b1_rsload", int'(obs0[3]), 1);
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("midrst_u0", int'(obs0), 0);
      chk("midrst_u1", int'(obs1), 0);
      op(4'b0011, 4'b0000, 1'b0, 1'b0);
      chk("after_rst_done", done_c[0], 12);
      chk("after_rst_load", nload[0], 2);

`ifdef MULT_CTRL_TAINT_CLR_EN
      op(4'b0110, 4'b0000, 1'b1, 1'b0);
      chk("clr_pre_tainted", int'(obs0[15:8] != 0), 1);
      taint_clr = 1'b1; cyc(); taint_clr = 1'b0;
      chk("clr_u0", int'(obs0), 0);
      chk("clr_u1", int'(obs1), 0);
      op(4'b0110, 4'b0000, 1'b1, 1'b1);
      chk("clr_beats_start_t", int'(tor[0]), 0);
      op(4'b1001, 4'b0000, 1'b0, 1'b0);
      chk("clr_clean_run", int'(tor[1]), 0);
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 39) == 0);
         start     = ($urandom_range(0, 2) == 0);
         start_t   = ($urandom_range(0, 15) == 0);
         taint_clr = ($urandom_range(0, 7) == 0);
         mr        = W'($urandom);
         mr_t      = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
         cyc();
      end
      start = 1'b0; start_t = 1'b0; taint_clr = 1'b0; mr_t = '0;
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("final_reset", int'(obs1), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
